// File: rtl/dds_pkg.sv
// ---------------------------------------------------------------------------
// dds_pkg : shared constants, quadrant encoding and sine-table helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dds_pkg;

    localparam int DDS_ACC_W  = 32;
    localparam int DDS_LUT_AW = 10;
    localparam int DDS_OUT_W  = 16;

    localparam int SINE_AMP = (1 << (DDS_OUT_W - 1)) - 1;

    // Sample latency from accumulator to SINE, used to align downstream paths
    localparam int DDS_LAT = 3;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quad_e;

    // Entry k = round(amp * sin(pi/2 * (k + 0.5) / 2^lut_aw)); Taylor series
    // is exact to well below one LSB over the first quadrant.
    function automatic int sine_entry(input int k, input int lut_aw, input int out_w);
        real x;
        real term;
        real sum;
        x    = 1.57079632679489661923 * ($itor(k) + 0.5) / $itor(1 << lut_aw);
        term = x;
        sum  = x;
        for (int n = 1; n < 10; n++) begin
            term = -term * x * x / $itor((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return $rtoi($itor((1 << (out_w - 1)) - 1) * sum + 0.5);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dds_quarter_rom.sv
// ---------------------------------------------------------------------------
// dds_quarter_rom : quarter-wave sine ROM, synchronous read gated by CE
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dds_quarter_rom
    import dds_pkg::*;
#(
    parameter int    LUT_AW   = DDS_LUT_AW,
    parameter int    OUT_W    = DDS_OUT_W,
    parameter string ROM_FILE = "sine_q.hex"
) (
    input  logic              CLK,
    input  logic              CE,
    input  logic [LUT_AW-1:0] ADDR,
    output logic [OUT_W-1:0]  DOUT
);

    localparam int c_depth = 1 << LUT_AW;

    logic [OUT_W-1:0] rom_w [c_depth];
    logic [OUT_W-1:0] dout_d;
    logic [OUT_W-1:0] dout_q;

    // The table is elaborated from the same formula that produces the named
    // image; an empty name means no table is fitted and the ROM reads zero.
    generate
        if (ROM_FILE != "") begin : g_table
            for (genvar k = 0; k < c_depth; k++) begin : g_entry
                localparam int c_val = sine_entry(k, LUT_AW, OUT_W);
                assign rom_w[k] = c_val[OUT_W-1:0];
            end
        end else begin : g_blank
            for (genvar k = 0; k < c_depth; k++) begin : g_entry
                assign rom_w[k] = '0;
            end
        end
    endgenerate

    always_comb begin
        dout_d = dout_q;
        if (CE) begin
            dout_d = rom_w[ADDR];
        end
    end

    // No reset on the data register so the array maps onto block RAM
    always_ff @(posedge CLK) begin
        dout_q <= dout_d;
    end

    assign DOUT = dout_q;

endmodule

`default_nettype wire

// File: rtl/dds_phase_sine.sv
// ---------------------------------------------------------------------------
// dds_phase_sine : phase accumulator + quadrant-folded quarter-wave sine
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dds_phase_sine
    import dds_pkg::*;
#(
    parameter int    ACC_W    = DDS_ACC_W,
    parameter int    LUT_AW   = DDS_LUT_AW,
    parameter int    OUT_W    = DDS_OUT_W,
    parameter string ROM_FILE = "sine_q.hex"
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic [ACC_W-1:0] FTW,
    input  logic             FTW_WE,
    input  logic [ACC_W-1:0] POW,
    input  logic             SYNC,
    output logic [OUT_W-1:0] SINE,
    output logic             VALID
);

    logic [ACC_W-1:0]   acc_d,  acc_q;
    logic [ACC_W-1:0]   ftw_d,  ftw_q;
    logic [LUT_AW-1:0]  addr_d, addr_q;
    logic               neg1_d, neg1_q;
    logic               neg2_d, neg2_q;
    logic [OUT_W-1:0]   sine_d, sine_q;
    logic [DDS_LAT-1:0] vld_d,  vld_q;

    logic [ACC_W-1:0]   phase_w;
    quad_e              quad_w;
    logic [LUT_AW-1:0]  idx_w;
    logic [OUT_W-1:0]   rom_dout;
    logic               phase_unused;

    assign phase_w = acc_q + POW;
    assign quad_w  = quad_e'(phase_w[ACC_W-1 -: 2]);
    assign idx_w   = phase_w[ACC_W-3 -: LUT_AW];

    // Phase bits below the ROM index only feed the carry chain
    assign phase_unused = ^phase_w[ACC_W-3-LUT_AW:0];

    always_comb begin
        ftw_d  = ftw_q;
        acc_d  = acc_q;
        addr_d = addr_q;
        neg1_d = neg1_q;
        neg2_d = neg2_q;
        sine_d = sine_q;
        vld_d  = vld_q;

        if (FTW_WE) begin
            ftw_d = FTW;
        end

        if (SYNC) begin
            acc_d = '0;
        end else if (CE) begin
            acc_d = acc_q + ftw_q;
        end

        if (CE) begin
            // Quadrants 1 and 3 run the quarter wave backwards; 2 and 3 are negative
            addr_d = ((quad_w == Q1) || (quad_w == Q3)) ? ~idx_w : idx_w;
            neg1_d = (quad_w == Q2) || (quad_w == Q3);
            neg2_d = neg1_q;
            sine_d = neg2_q ? -rom_dout : rom_dout;
        end

        if (SYNC) begin
            vld_d = '0;
        end else if (CE) begin
            vld_d = {vld_q[DDS_LAT-2:0], 1'b1};
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            acc_q  <= '0;
            ftw_q  <= '0;
            addr_q <= '0;
            neg1_q <= 1'b0;
            neg2_q <= 1'b0;
            sine_q <= '0;
            vld_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            ftw_q  <= ftw_d;
            addr_q <= addr_d;
            neg1_q <= neg1_d;
            neg2_q <= neg2_d;
            sine_q <= sine_d;
            vld_q  <= vld_d;
        end
    end

    dds_quarter_rom #(
        .LUT_AW   (LUT_AW),
        .OUT_W    (OUT_W),
        .ROM_FILE (ROM_FILE)
    ) u_rom (
        .CLK  (CLK),
        .CE   (CE),
        .ADDR (addr_q),
        .DOUT (rom_dout)
    );

    assign SINE  = sine_q;
    assign VALID = vld_q[DDS_LAT-1];

endmodule

`default_nettype wire

// File: tb/tb_dds_phase_sine.sv
// ---------------------------------------------------------------------------
// tb_dds_phase_sine : directed self-checking bench for dds_phase_sine
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_dds_phase_sine;

    localparam logic [15:0] P25  = 16'd25;
    localparam logic [15:0] PMAX = 16'd32767;
    localparam logic [15:0] N25  = 16'hFFE7;
    localparam logic [15:0] NMAX = 16'h8001;
    localparam logic [15:0] SEQ [4] = '{P25, PMAX, N25, NMAX};

    logic        CLK    = 1'b0;
    logic        RST    = 1'b0;
    logic        CE     = 1'b0;
    logic [31:0] FTW    = '0;
    logic        FTW_WE = 1'b0;
    logic [31:0] POW    = '0;
    logic        SYNC   = 1'b0;
    logic [15:0] SINE;
    logic        VALID;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    dds_phase_sine #(
        .ACC_W    (32),
        .LUT_AW   (10),
        .OUT_W    (16),
        .ROM_FILE ("sine_q.hex")
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .CE     (CE),
        .FTW    (FTW),
        .FTW_WE (FTW_WE),
        .POW    (POW),
        .SYNC   (SYNC),
        .SINE   (SINE),
        .VALID  (VALID)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        #2;
        chk16("reset_sine", SINE, 16'h0000);
        chk1("reset_valid", VALID, 1'b0);
        step();
        step();
        chk16("reset_sine_held", SINE, 16'h0000);

        // Release with FTW=0, POW=0
        RST = 1'b1;
        CE  = 1'b1;
        step();
        chk1("start_valid_e1", VALID, 1'b0);
        step();
        chk1("start_valid_e2", VALID, 1'b0);
        step();
        chk1("start_valid_e3", VALID, 1'b1);
        chk16("start_sine_e3", SINE, P25);
        for (int i = 0; i < 3; i++) begin
            step();
            chk16("dc_sine", SINE, P25);
        end

        // Quarter-rate tone: first new phase reaches SINE on the 3rd edge after load+1
        FTW    = 32'h4000_0000;
        FTW_WE = 1'b1;
        step();
        FTW_WE = 1'b0;
        step();
        step();
        for (int i = 0; i < 6; i++) begin
            step();
            chk16("quarter_seq", SINE, SEQ[i % 4]);
        end

        // Stall: last sample was full scale, next must be -25
        CE = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk16("stall_sine", SINE, PMAX);
            chk1("stall_valid", VALID, 1'b1);
        end
        CE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk16("resume_seq", SINE, SEQ[(i + 2) % 4]);
        end

        // Phase restart
        SYNC = 1'b1;
        step();
        SYNC = 1'b0;
        chk1("sync_valid_e0", VALID, 1'b0);
        step();
        chk1("sync_valid_e1", VALID, 1'b0);
        step();
        chk1("sync_valid_e2", VALID, 1'b0);
        step();
        chk1("sync_valid_e3", VALID, 1'b1);
        chk16("sync_seq0", SINE, P25);
        step();
        chk16("sync_seq1", SINE, PMAX);
        step();
        chk16("sync_seq2", SINE, N25);

        // SYNC and FTW_WE together: acc=0, ftw=0
        SYNC   = 1'b1;
        FTW    = 32'h0000_0000;
        FTW_WE = 1'b1;
        step();
        SYNC   = 1'b0;
        FTW_WE = 1'b0;
        chk1("sync_we_valid", VALID, 1'b0);
        POW = 32'h8000_0000;
        step();
        step();
        step();
        chk16("pow_half", SINE, N25);
        chk1("pow_half_valid", VALID, 1'b1);
        POW = 32'hC000_0000;
        step();
        step();
        chk16("pow_latency", SINE, N25);
        step();
        chk16("pow_three_quarter", SINE, NMAX);
        POW = 32'h0000_0000;

        // Asynchronous reset mid-run
        FTW    = 32'h4000_0000;
        FTW_WE = 1'b1;
        step();
        FTW_WE = 1'b0;
        step();
        step();
        step();
        #2;
        RST = 1'b0;
        #1;
        chk16("async_rst_sine", SINE, 16'h0000);
        chk1("async_rst_valid", VALID, 1'b0);
        step();
        RST = 1'b1;
        step();
        chk1("rerel_valid_e1", VALID, 1'b0);
        step();
        chk1("rerel_valid_e2", VALID, 1'b0);
        step();
        chk1("rerel_valid_e3", VALID, 1'b1);
        chk16("rerel_sine_e3", SINE, P25);
        step();
        chk16("rerel_sine_dc", SINE, P25);

        // All-ones FTW steps backwards; phase just below 2*pi folds to the smallest entry
        FTW    = 32'hFFFF_FFFF;
        FTW_WE = 1'b1;
        step();
        FTW_WE = 1'b0;
        step();
        step();
        step();
        chk16("wrap_first", SINE, P25);
        for (int i = 0; i < 3; i++) begin
            step();
            chk16("wrap_neg", SINE, N25);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
